// File: rtl/raster_fifo_ctrl_pkg.sv
// Shared raster definitions: controller states, source tags and FIFO entry layout.
package raster_fifo_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Each FIFO entry carries the source tag above the sample: {src_id, sample}.
  function automatic int entry_wid(input int dat_wid);
    return dat_wid + 1;
  endfunction

endpackage

// File: rtl/raster_fifo_ctrl_ram_fifo.sv
// Single-clock circular RAM FIFO with a one-cycle registered read and an occupancy counter.
module raster_fifo_ctrl_ram_fifo #(
  parameter int WID     = 25,
  parameter int DEPTH   = 1500,
  parameter int LVL_WID = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write_enable,
  input  logic [WID-1:0]     write_dat,
  input  logic               read_enable,
  output logic [WID-1:0]     read_dat,
  output logic [LVL_WID-1:0] level
);

  localparam int                 PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [LVL_WID-1:0] LVL_FULL = LVL_WID'(DEPTH);

  logic [WID-1:0]     mem_q [DEPTH];
  logic [WID-1:0]     rd_dat_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [LVL_WID-1:0] level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (write_enable) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (read_enable)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({write_enable, read_enable})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage stays out of reset; only the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (write_enable) mem_q[wr_ptr_q] <= write_dat;
    if (read_enable)  rd_dat_q <= mem_q[rd_ptr_q];
  end

  assign read_dat = rd_dat_q;
  assign level    = level_q;

  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(read_enable && level_q == '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(write_enable && level_q == LVL_FULL));

endmodule

// File: rtl/raster_fifo_ctrl.sv
// Shares one sample FIFO between producers A and B (round-robin, source-tagged) and drains it
// to a valid/ready consumer through a 2-entry registered output buffer, with flush control.
module raster_fifo_ctrl
  import raster_fifo_ctrl_pkg::*;
#(
  parameter int DAT_WID        = 24,
  parameter int FIFO_DEPTH     = 1500,
  parameter int FIFO_DEPTH_WID = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      flush,
  input  logic                      a_valid,
  input  logic signed [DAT_WID-1:0] a_dat,
  output logic                      a_ready,
  input  logic                      b_valid,
  input  logic signed [DAT_WID-1:0] b_dat,
  output logic                      b_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DAT_WID-1:0] out_dat,
  output logic                      out_src,
  output logic [FIFO_DEPTH_WID-1:0] fifo_level,
  output logic                      busy
);

  localparam int                        ENT_W    = entry_wid(DAT_WID);
  localparam logic [FIFO_DEPTH_WID-1:0] LVL_FULL = FIFO_DEPTH_WID'(FIFO_DEPTH);

  state_e                    state_q;
  logic                      last_b_q;
  logic                      inflight_q;
  logic [1:0]                buf_cnt_q;
  logic signed [DAT_WID-1:0] buf0_dat_q;
  logic signed [DAT_WID-1:0] buf1_dat_q;
  logic                      buf0_src_q;
  logic                      buf1_src_q;

  logic             wr_ok, grant_a, grant_b, wr_en, rd_en, pop, push;
  logic [ENT_W-1:0] wr_dat, rd_dat;
  logic [2:0]       credit;

  // Write side: a single grant per cycle; on contention the source not granted last wins.
  assign wr_ok   = !rst && (state_q == ST_RUN) && enable && (fifo_level < LVL_FULL);
  assign grant_a = wr_ok && a_valid && (!b_valid || last_b_q);
  assign grant_b = wr_ok && b_valid && (!a_valid || !last_b_q);
  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign wr_en   = grant_a || grant_b;
  assign wr_dat  = grant_b ? {SRC_B, b_dat} : {SRC_A, a_dat};

  // Read side: keep buffered plus in-flight words below two after this cycle's pop.
  assign pop    = out_valid && out_ready;
  assign credit = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en  = (fifo_level != '0) && ((state_q == ST_FLUSH) || (credit < 3'd2));
  assign push   = inflight_q && (state_q == ST_RUN);

  raster_fifo_ctrl_ram_fifo #(
    .WID     (ENT_W),
    .DEPTH   (FIFO_DEPTH),
    .LVL_WID (FIFO_DEPTH_WID)
  ) u_ram_fifo (
    .clk          (clk),
    .rst          (rst),
    .write_enable (wr_en),
    .write_dat    (wr_dat),
    .read_enable  (rd_en),
    .read_dat     (rd_dat),
    .level        (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      last_b_q   <= 1'b1;
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      buf0_dat_q <= '0;
      buf0_src_q <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      if (wr_en) last_b_q <= grant_b;
      case (state_q)
        ST_RUN: begin
          if (flush) begin
            state_q   <= ST_FLUSH;
            buf_cnt_q <= 2'd0;
          end else begin
            case ({push, pop})
              2'b10: begin
                if (buf_cnt_q == 2'd0) begin
                  buf0_dat_q <= $signed(rd_dat[DAT_WID-1:0]);
                  buf0_src_q <= rd_dat[DAT_WID];
                end else begin
                  buf1_dat_q <= $signed(rd_dat[DAT_WID-1:0]);
                  buf1_src_q <= rd_dat[DAT_WID];
                end
                buf_cnt_q <= buf_cnt_q + 2'd1;
              end
              2'b01: begin
                buf0_dat_q <= buf1_dat_q;
                buf0_src_q <= buf1_src_q;
                buf_cnt_q  <= buf_cnt_q - 2'd1;
              end
              2'b11: begin
                if (buf_cnt_q == 2'd1) begin
                  buf0_dat_q <= $signed(rd_dat[DAT_WID-1:0]);
                  buf0_src_q <= rd_dat[DAT_WID];
                end else begin
                  buf0_dat_q <= buf1_dat_q;
                  buf0_src_q <= buf1_src_q;
                  buf1_dat_q <= $signed(rd_dat[DAT_WID-1:0]);
                  buf1_src_q <= rd_dat[DAT_WID];
                end
              end
              default: ;
            endcase
          end
        end
        ST_FLUSH: begin
          // Returned words are dropped; leave once nothing is stored or still on its way.
          if (!flush && fifo_level == '0 && !inflight_q && buf_cnt_q == 2'd0)
            state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign out_valid = (buf_cnt_q != 2'd0);
  assign out_dat   = buf0_dat_q;
  assign out_src   = buf0_src_q;
  assign busy      = (state_q == ST_FLUSH);

endmodule
